// File: rtl/multi_div_pkg.sv
// multi_div_pkg: op encoding and FSM state type shared by the multiply/divide unit
package multi_div_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_t;
endpackage

// File: rtl/multi_div_seq_md_iter_step.sv
// md_iter_step: one combinational iteration (multiply add-shift or divide shift-subtract)
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH:0]   acc_nxt
);
  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] mt;
  logic [2*WIDTH:0] sh;
  logic [WIDTH+1:0] diff;
  // acc is {hi(W+1),lo(W)}: product accumulator for multiply, {rem,quot} for divide
  always_comb begin
    sum     = acc[2*WIDTH:WIDTH] + {1'b0, opnd};
    mt      = acc[0] ? {sum, acc[WIDTH-1:0]} : acc;
    sh      = {acc[2*WIDTH-1:0], 1'b0};
    diff    = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b0, opnd};
    acc_nxt = is_div ? (diff[WIDTH+1] ? sh : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1})
                     : {1'b0, mt[2*WIDTH:1]};
  end
endmodule

// File: rtl/multi_div_seq.sv
// multi_div_seq: iterative signed/unsigned multiply/divide, one bit per clock; MULTI_DIV_SEQ_EARLY_EXIT_EN enables trivial-case early exit
module multi_div_seq
  import multi_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_high,
  output logic [WIDTH-1:0] out_low,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic [2*WIDTH:0] acc_q, acc_d, acc_step, acc_init;
  logic [WIDTH-1:0] opnd_q, opnd_d, out_high_q, out_high_d, out_low_q, out_low_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, zb_q, zb_d;
  logic busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;
  logic is_div, is_sgn, a_s, b_s, zero_div, lt, early, accept;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag;
  logic [2*WIDTH-1:0] prod_s;
  assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign is_sgn   = (op == OP_MULT) || (op == OP_DIV);
  assign a_s      = is_sgn & data_a[WIDTH-1];
  assign b_s      = is_sgn & data_b[WIDTH-1];
  assign a_mag    = a_s ? -data_a : data_a;
  assign b_mag    = b_s ? -data_b : data_b;
  assign zero_div = is_div && (data_b == '0);
  assign accept   = (state_q == ST_IDLE) && start;
`ifdef MULTI_DIV_SEQ_EARLY_EXIT_EN
  assign lt    = a_mag < b_mag;
  assign early = is_div ? (lt || (b_mag == WIDTH'(1))) : ((data_a == '0) || (data_b == '0));
`else
  assign lt    = 1'b0;
  assign early = 1'b0;
`endif
  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (div_q),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_step)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  // next-state logic
  always_comb begin
    state_d = (state_q == ST_IDLE) ? (start ? (zero_div ? ST_DONE : early ? ST_FIX : ST_CALC) : ST_IDLE) :
              (state_q == ST_CALC) ? ((cnt_q == CNT_W'(1)) ? ST_FIX : ST_CALC) :
              (state_q == ST_FIX)  ? ST_DONE : ST_IDLE;
  end
  // datapath and output next values; early-exit starts preload the final accumulator
  always_comb begin
    acc_init   = is_div ? (lt ? {1'b0, a_mag, {WIDTH{1'b0}}} : {{(WIDTH+1){1'b0}}, a_mag})
                        : (early ? '0 : {{(WIDTH+1){1'b0}}, b_mag});
    acc_d      = accept ? acc_init : (state_q == ST_CALC) ? acc_step : acc_q;
    opnd_d     = accept ? (is_div ? b_mag : a_mag) : opnd_q;
    div_d      = accept ? is_div : div_q;
    neg_d      = accept ? (a_s ^ b_s) : neg_q;
    rneg_d     = accept ? a_s : rneg_q;
    zb_d       = accept ? zero_div : zb_q;
    cnt_d      = accept ? CNT_W'(WIDTH) : (state_q == ST_CALC) ? cnt_q - CNT_W'(1) : cnt_q;
    busy_d     = accept ? 1'b1 : (state_q == ST_DONE) ? 1'b0 : busy_q;
    done_d     = state_q == ST_DONE;
    div_zero_d = accept ? 1'b0 : ((state_q == ST_DONE) && zb_q) ? 1'b1 : div_zero_q;
    prod_s     = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    q_mag      = acc_q[WIDTH-1:0];
    r_mag      = acc_q[2*WIDTH-1:WIDTH];
    out_high_d = (state_q != ST_FIX) ? out_high_q : div_q ? (rneg_q ? -r_mag : r_mag) : prod_s[2*WIDTH-1:WIDTH];
    out_low_d  = (state_q != ST_FIX) ? out_low_q  : div_q ? (neg_q ? -q_mag : q_mag) : prod_s[WIDTH-1:0];
  end
  // datapath and output registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc_q      <= '0;
      opnd_q     <= '0;
      div_q      <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      zb_q       <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      out_high_q <= '0;
      out_low_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      div_q      <= div_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      zb_q       <= zb_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      out_high_q <= out_high_d;
      out_low_q  <= out_low_d;
    end
  assign busy     = busy_q;
  assign done     = done_q;
  assign out_high = out_high_q;
  assign out_low  = out_low_q;
  assign div_zero = div_zero_q;
endmodule
